sc_unary_stream_tx: RTL and testbench
=====================================

# sc_unary_stream_tx

Deterministic stochastic-computing stream transmitter: accepts a WIDTH-bit binary operand over a valid/ready handshake and emits it as a unary (thermometer) bitstream, LANES bits per beat, optionally repeated for clock-division. It is the encoding end that feeds the multi-lane AND-multiplier and parallel-accumulator decoders. Streams are accepted back-to-back, and downstream backpressure is honoured.

## Interface
- WIDTH, 5: operand width; one period is 2^WIDTH bits.
- LANES, 2: bits emitted per beat; power of two, at most 2^WIDTH.
- REPEAT_LOG2, 0: the stream is 2^REPEAT_LOG2 identical periods.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand available.
- in_ready  out  1  transmitter can accept an operand.
- in_data  in  WIDTH  binary operand, value v in 0..2^WIDTH-1.
- out_ready  in  1  downstream accepts the current beat.
- sn_valid  out  1  sn_out holds a valid beat.
- sn_out  out  LANES  stream bits; lane l carries stream bit index k0+l.
- period_end  out  1  current beat is the last beat of a period.
- last  out  1  current beat is the final beat of the stream.
- busy  out  1  a stream is in progress.

## Operation
- States: IDLE, STREAM.
- IDLE: in_ready=1, sn_valid=0. A transfer (in_valid&in_ready) latches v, clears k0 and the repeat counter, and moves to STREAM.
- STREAM: sn_valid=1, busy=1. Lane bit l = ((k0+l) < v), compared at WIDTH+1 bits; k0 counts by LANES.
- A beat transfers when sn_valid&out_ready. With out_ready=0, sn_out, period_end, last and all counters hold.
- On a transfer with k0 = 2^WIDTH-LANES: period_end=1, k0 wraps to 0, and the repeat counter increments.
- last = period_end on the final period (repeat counter = 2^REPEAT_LOG2-1).
- in_ready = IDLE | (last & out_ready).
  - If a last-beat transfer coincides with an input transfer, the new v is latched, the counters clear, and the state stays in STREAM, with no bubble.
  - Otherwise a last-beat transfer returns the block to IDLE.
- Period popcount equals v. Stream popcount equals v·2^REPEAT_LOG2.
- in_data is ignored outside in_valid&in_ready.
- rst low at any time, including mid-stream, forces IDLE immediately:
  - the stream is abandoned and no beat is flagged last;
  - v, k0 and the repeat counter clear.

## Timing
- Reset values: in_ready=1, sn_valid=0, sn_out=0, period_end=0, last=0, busy=0.
- All outputs derive from registers. There is no combinational path from in_data or in_valid to any output, and none from out_ready to anything except in_ready.
- Latency: an operand accepted at edge N gives its first beat valid in cycle N+1.
- Stream length, with out_ready held high: 2^(WIDTH+REPEAT_LOG2)/LANES beats.
- Throughput: one beat per cycle. Back-to-back streams have zero idle cycles.

## Configuration
- SC_TX_EARLY_DONE_EN, defined:
  - In the final period, the first beat with k0 >= v is flagged last, and the stream ends there. All its lanes are 0.
  - period_end is also asserted on that beat.
  - v=0 with REPEAT_LOG2=0 yields a single all-zero beat.
  - Earlier periods are emitted in full.
- SC_TX_EARLY_DONE_EN, undefined: every stream has the full length. Popcount semantics are identical in both builds.

## Test plan
- WIDTH=5, LANES=2, REPEAT_LOG2=0, v=5, out_ready=1 -> 16 beats; sn_out = 11,11,01, then 00×13; last and period_end on beat 16 only; popcount 5.
- v=31 -> beats 1..15 are 11, beat 16 is 01 with last=1; v=0 -> 16 beats of 00.
- REPEAT_LOG2=2, v=3 -> 64 beats; period_end on beats 16/32/48/64; last on beat 64 only; popcount 12.
- Backpressure: out_ready toggled 1,0,0,1… during v=7 -> no beat dropped or duplicated; outputs stable while stalled; popcount 7.
- Back-to-back v=9 then v=2, in_valid held -> second operand accepted on the last-beat edge; its first beat follows immediately; 32 contiguous beats.
- Reset mid-stream at beat 6: rst low -> sn_valid=0, in_ready=1 asynchronously; the next operand restarts from k0=0.
- With SC_TX_EARLY_DONE_EN, v=5 -> 4 beats (11,11,01,00), last on beat 4; v=0 -> 1 beat 00 with last=1.

Source files
------------

// File: rtl/sc_unary_stream_tx.sv
// Unary (thermometer) stochastic-computing stream transmitter, LANES bits per beat, 2^REPEAT_LOG2 periods per operand.
// Build option SC_TX_EARLY_DONE_EN: the final period stops at its first beat with k0 >= v.
module sc_unary_stream_tx #(
    parameter int WIDTH       = 5,
    parameter int LANES       = 2,
    parameter int REPEAT_LOG2 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             sn_valid,
    output logic [LANES-1:0] sn_out,
    output logic             period_end,
    output logic             last,
    output logic             busy
);
    localparam int               RW       = (REPEAT_LOG2 > 0) ? REPEAT_LOG2 : 1;
    localparam int               W1       = WIDTH + 1;
    localparam logic [WIDTH-1:0] K_LAST   = WIDTH'((2 ** WIDTH) - LANES);
    localparam logic [WIDTH-1:0] K_STEP   = WIDTH'(LANES);
    localparam logic [RW-1:0]    REP_LAST = RW'((2 ** REPEAT_LOG2) - 1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_v;
    logic [WIDTH-1:0] r_k0;
    logic [RW-1:0]    r_rep;
    logic             r_sn_valid;
    logic [LANES-1:0] r_sn_out;
    logic             r_period_end;
    logic             r_last;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_v_nxt;
    logic [WIDTH-1:0] w_k0_nxt;
    logic [RW-1:0]    w_rep_nxt;
    logic             w_in_xfer;
    logic             w_beat_xfer;
    logic             w_stream_nxt;
    logic             w_final_nxt;
    logic             w_end_nxt;

    // Lane l is one while its stream bit index k0+l is below v; compared one bit wider to avoid wrap.
    function automatic logic [LANES-1:0] lane_bits(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] k0);
        logic [LANES-1:0] bits;
        bits = {LANES{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            bits[l] = (({1'b0, k0} + W1'(l)) < {1'b0, v});
        end
        return bits;
    endfunction

    assign in_ready    = (r_state == IDLE) | (r_last & out_ready);
    assign w_in_xfer   = in_valid & in_ready;
    assign w_beat_xfer = r_sn_valid & out_ready;

    // Next operand/position/period; a new operand on the last-beat edge restarts with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_k0_nxt    = r_k0;
        w_rep_nxt   = r_rep;
        if (w_in_xfer) begin
            w_state_nxt = STREAM;
            w_v_nxt     = in_data;
            w_k0_nxt    = {WIDTH{1'b0}};
            w_rep_nxt   = {RW{1'b0}};
        end else if (w_beat_xfer) begin
            if (r_last) begin
                w_state_nxt = IDLE;
                w_k0_nxt    = {WIDTH{1'b0}};
                w_rep_nxt   = {RW{1'b0}};
            end else if (r_k0 == K_LAST) begin
                w_k0_nxt  = {WIDTH{1'b0}};
                w_rep_nxt = r_rep + RW'(1);
            end else begin
                w_k0_nxt = r_k0 + K_STEP;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Flags describing the beat that will be presented after this edge.
    always_comb begin
        w_stream_nxt = (w_state_nxt == STREAM);
        w_final_nxt  = (w_rep_nxt == REP_LAST);
`ifdef SC_TX_EARLY_DONE_EN
        w_end_nxt    = (w_k0_nxt == K_LAST) | (w_final_nxt & (w_k0_nxt >= w_v_nxt));
`else
        w_end_nxt    = (w_k0_nxt == K_LAST);
`endif
    end

    // State, counters and registered outputs; outputs hold whenever no transfer happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_v          <= {WIDTH{1'b0}};
            r_k0         <= {WIDTH{1'b0}};
            r_rep        <= {RW{1'b0}};
            r_sn_valid   <= 1'b0;
            r_sn_out     <= {LANES{1'b0}};
            r_period_end <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_v          <= w_v_nxt;
            r_k0         <= w_k0_nxt;
            r_rep        <= w_rep_nxt;
            r_sn_valid   <= w_stream_nxt;
            r_busy       <= w_stream_nxt;
            r_sn_out     <= w_stream_nxt ? lane_bits(w_v_nxt, w_k0_nxt) : {LANES{1'b0}};
            r_period_end <= w_stream_nxt & w_end_nxt;
            r_last       <= w_stream_nxt & w_end_nxt & w_final_nxt;
        end
    end

    assign sn_valid   = r_sn_valid;
    assign sn_out     = r_sn_out;
    assign period_end = r_period_end;
    assign last       = r_last;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sc_unary_stream_tx.sv
// Randomized bench for sc_unary_stream_tx: two instances (REPEAT_LOG2 = 0 and 2) checked against a stream-level reference model.
module tb_sc_unary_stream_tx;
    localparam int WIDTH = 5;
    localparam int LANES = 2;
    localparam int PLEN  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_a   [2];
    logic             in_ready_a   [2];
    logic [WIDTH-1:0] in_data_a    [2];
    logic             out_ready_a  [2];
    logic             sn_valid_a   [2];
    logic [LANES-1:0] sn_out_a     [2];
    logic             period_end_a [2];
    logic             last_a       [2];
    logic             busy_a       [2];

    typedef struct {
        logic [LANES-1:0] bits;
        bit               pe;
        bit               last;
    } beat_t;

    beat_t exp_q [$];
    int    ops_q [$];
    int    tests_run = 0;
    int    fails     = 0;

    always #5 clk = ~clk;

    sc_unary_stream_tx #(.WIDTH(WIDTH), .LANES(LANES), .REPEAT_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_data(in_data_a[0]), .out_ready(out_ready_a[0]), .sn_valid(sn_valid_a[0]),
        .sn_out(sn_out_a[0]), .period_end(period_end_a[0]), .last(last_a[0]), .busy(busy_a[0]));

    sc_unary_stream_tx #(.WIDTH(WIDTH), .LANES(LANES), .REPEAT_LOG2(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_data(in_data_a[1]), .out_ready(out_ready_a[1]), .sn_valid(sn_valid_a[1]),
        .sn_out(sn_out_a[1]), .period_end(period_end_a[1]), .last(last_a[1]), .busy(busy_a[1]));

    // Reference: stream bit i of a period is 1 iff i < v; period repeated 2^rl times.
    task automatic push_stream(input int v, input int rl);
        beat_t b;
        for (int p = 0; p < (1 << rl); p++) begin
            for (int i = 0; i < PLEN; i += LANES) begin
                for (int l = 0; l < LANES; l++) b.bits[l] = ((i + l) < v);
                b.pe   = (i + LANES == PLEN);
                b.last = b.pe && (p == (1 << rl) - 1);
`ifdef SC_TX_EARLY_DONE_EN
                if ((p == (1 << rl) - 1) && (i >= v)) begin
                    b.pe   = 1'b1;
                    b.last = 1'b1;
                    exp_q.push_back(b);
                    return;
                end
`endif
                exp_q.push_back(b);
            end
        end
    endtask

    // Drives ops_q into instance d; mode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic run_ops(input int d, input int mode, input bit gaps);
        int cyc = 0, ones = 0, exp_ones = 0, pi = 0, beats = 0;
        int n_ops = ops_q.size();
        int rl = (d == 1) ? 2 : 0;
        bit orq, iv, exp_ir;
        exp_q.delete();
        foreach (ops_q[i]) exp_ones += ops_q[i] << rl;
        while ((pi < n_ops || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                tests_run++;
                if (sn_valid_a[d] !== 1'b1 || busy_a[d] !== 1'b1 || sn_out_a[d] !== exp_q[0].bits ||
                    period_end_a[d] !== exp_q[0].pe || last_a[d] !== exp_q[0].last) begin
                    fails++;
                    $display("FAIL beat dut%0d cyc%0d: got v=%b b=%b out=%b pe=%b last=%b, want v=1 b=1 out=%b pe=%b last=%b",
                             d, cyc, sn_valid_a[d], busy_a[d], sn_out_a[d], period_end_a[d], last_a[d],
                             exp_q[0].bits, exp_q[0].pe, exp_q[0].last);
                end
            end else begin
                tests_run++;
                if (sn_valid_a[d] !== 1'b0 || busy_a[d] !== 1'b0 || sn_out_a[d] !== '0 || last_a[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL idle dut%0d cyc%0d: got v=%b b=%b out=%b last=%b, want all 0",
                             d, cyc, sn_valid_a[d], busy_a[d], sn_out_a[d], last_a[d]);
                end
            end
            orq = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom % 2);
            iv  = (pi < n_ops) && (!gaps || ($urandom % 3 != 0));
            out_ready_a[d] = orq;
            in_valid_a[d]  = iv;
            in_data_a[d]   = iv ? WIDTH'(ops_q[pi]) : WIDTH'($urandom);
            #1;
            exp_ir = (exp_q.size() == 0) || (exp_q[0].last && orq);
            tests_run++;
            if (in_ready_a[d] !== exp_ir) begin
                fails++;
                $display("FAIL in_ready dut%0d cyc%0d: got %b want %b", d, cyc, in_ready_a[d], exp_ir);
            end
            if (exp_q.size() > 0 && orq) begin
                ones += $countones(sn_out_a[d]);
                beats++;
                void'(exp_q.pop_front());
            end
            if (iv && exp_ir) begin
                push_stream(ops_q[pi], rl);
                pi++;
            end
            cyc++;
        end
        tests_run++;
        if (cyc >= 3000) begin
            fails++;
            $display("FAIL timeout dut%0d: got %0d cycles, want < 3000", d, cyc);
        end
        in_valid_a[d] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (sn_valid_a[d] !== 1'b0 || in_ready_a[d] !== 1'b1) begin
            fails++;
            $display("FAIL end_idle dut%0d: got valid=%b ready=%b, want 0 1", d, sn_valid_a[d], in_ready_a[d]);
        end
        tests_run++;
        if (ones != exp_ones) begin
            fails++;
            $display("FAIL popcount dut%0d: got %0d want %0d", d, ones, exp_ones);
        end
`ifndef SC_TX_EARLY_DONE_EN
        tests_run++;
        if (beats != n_ops * ((PLEN / LANES) << rl)) begin
            fails++;
            $display("FAIL beat_count dut%0d: got %0d want %0d", d, beats, n_ops * ((PLEN / LANES) << rl));
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (in_ready_a[d] !== 1'b1 || sn_valid_a[d] !== 1'b0 || sn_out_a[d] !== '0 ||
                period_end_a[d] !== 1'b0 || last_a[d] !== 1'b0 || busy_a[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset dut%0d: got rdy=%b v=%b out=%b pe=%b last=%b busy=%b, want 1 0 00 0 0 0",
                         d, in_ready_a[d], sn_valid_a[d], sn_out_a[d], period_end_a[d], last_a[d], busy_a[d]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_directed;
        ops_q = '{5};  run_ops(0, 0, 1'b0);
        ops_q = '{31}; run_ops(0, 0, 1'b0);
        ops_q = '{0};  run_ops(0, 0, 1'b0);
        ops_q = '{3};  run_ops(1, 0, 1'b0);
        ops_q = '{0};  run_ops(1, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        ops_q = '{7};  run_ops(0, 1, 1'b0);
        ops_q = '{int'($urandom_range(0, 31))}; run_ops(1, 1, 1'b0);
    endtask

    task automatic test_back_to_back;
        ops_q = '{9, 2};     run_ops(0, 0, 1'b0);
        ops_q = '{31, 0, 1}; run_ops(0, 0, 1'b0);
        ops_q = '{4, 6};     run_ops(1, 2, 1'b0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            ops_q.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) ops_q.push_back(int'($urandom_range(0, 31)));
            run_ops(it % 2, 2, 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        in_data_a[0]   = 5'd20;
        @(negedge clk);
        in_valid_a[0]  = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (sn_valid_a[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_stream dut0: got valid=%b want 1", sn_valid_a[0]);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (sn_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || last_a[0] !== 1'b0 ||
            busy_a[0] !== 1'b0 || sn_out_a[0] !== '0 || period_end_a[0] !== 1'b0) begin
            fails++;
            $display("FAIL async_reset dut0: got v=%b rdy=%b last=%b busy=%b out=%b pe=%b, want 0 1 0 0 00 0",
                     sn_valid_a[0], in_ready_a[0], last_a[0], busy_a[0], sn_out_a[0], period_end_a[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        ops_q = '{int'($urandom_range(1, 31))};
        run_ops(0, 0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d]  = 1'b0;
            in_data_a[d]   = '0;
            out_ready_a[d] = 1'b0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
